// File: rtl/agu_pkg.sv
// Shared select codes and FSM encoding for the address generation unit.
// Optional PENALTY_CNT output is enabled by defining AGU_PENALTY_CNT_EN.
package agu_pkg;

  localparam logic [2:0] SEL_PC    = 3'b000;
  localparam logic [2:0] SEL_MAR   = 3'b001;
  localparam logic [2:0] SEL_EA    = 3'b010;
  localparam logic [2:0] SEL_STACK = 3'b011;
  localparam logic [2:0] SEL_VEC   = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FIX  = 2'b01,
    DONE = 2'b10
  } agu_state_e;

endpackage

// File: rtl/addr_src_mux.sv
// Combinational five-source address bus multiplexer.
// Unused select codes drive an all-zero bus.
module addr_src_mux
  import agu_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int PAGE_BITS  = 8,
  parameter int STACK_PAGE = 1
) (
  input  logic [2:0]           sel_i,
  input  logic [ADDR_W-1:0]    pc_i,
  input  logic [ADDR_W-1:0]    mar_i,
  input  logic [ADDR_W-1:0]    ea_i,
  input  logic [PAGE_BITS-1:0] sp_i,
  input  logic [ADDR_W-1:0]    vec_i,
  output logic [ADDR_W-1:0]    bus_o
);

  localparam int HI_W = ADDR_W - PAGE_BITS;

  logic [HI_W-1:0] stack_hi;

  assign stack_hi = HI_W'(STACK_PAGE);

  always_comb begin
    bus_o = '0;
    case (sel_i)
      SEL_PC:    bus_o = pc_i;
      SEL_MAR:   bus_o = mar_i;
      SEL_EA:    bus_o = ea_i;
      SEL_STACK: bus_o = {stack_hi, sp_i};
      SEL_VEC:   bus_o = vec_i;
      default:   bus_o = '0;
    endcase
  end

endmodule

// File: rtl/addr_gen_unit.sv
// Address bus mux plus indexed/zero-page EA calculator with page-cross fix-up.
// Define AGU_PENALTY_CNT_EN to add the saturating PENALTY_CNT output.
module addr_gen_unit
  import agu_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int PAGE_BITS  = 8,
  parameter int STACK_PAGE = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [ADDR_W-1:0]    OUT_PC,
  input  logic [ADDR_W-1:0]    OUT_MAR,
  input  logic [ADDR_W-1:0]    VECTOR_ADDR,
  input  logic [PAGE_BITS-1:0] SP,
  input  logic [ADDR_W-1:0]    BASE_ADDR,
  input  logic [PAGE_BITS-1:0] INDEX,
  input  logic                 ZP_MODE,
  input  logic                 START,
  input  logic [2:0]           SELECT_ADRESS,
  output logic [ADDR_W-1:0]    OUT_ADRESS_BUS,
  output logic                 EA_VALID,
  output logic                 PAGE_CROSS,
  output logic                 BUSY
`ifdef AGU_PENALTY_CNT_EN
  ,
  output logic [15:0]          PENALTY_CNT
`endif
);

  localparam int HI_W = ADDR_W - PAGE_BITS;

  agu_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   ea_q, ea_d;
  logic                cross_q, cross_d;
  logic [PAGE_BITS:0]  sum;
  logic [HI_W-1:0]     ea_hi_inc;
  logic                accept;

  assign sum = {1'b0, BASE_ADDR[PAGE_BITS-1:0]}
             + {1'b0, INDEX};
  assign ea_hi_inc = ea_q[ADDR_W-1:PAGE_BITS] + HI_W'(1);
  assign accept = START && (state_q != FIX);

  always_comb begin
    state_d = state_q;
    ea_d    = ea_q;
    cross_d = cross_q;
    unique case (state_q)
      IDLE, DONE: state_d = IDLE;
      FIX: begin
        ea_d    = {ea_hi_inc, ea_q[PAGE_BITS-1:0]};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      cross_d = 1'b0;
      state_d = DONE;
      if (ZP_MODE) begin
        ea_d = {{HI_W{1'b0}}, sum[PAGE_BITS-1:0]};
      end else begin
        // Uncorrected address is exposed during FIX as the dummy read
        ea_d = {BASE_ADDR[ADDR_W-1:PAGE_BITS],
                sum[PAGE_BITS-1:0]};
        if (sum[PAGE_BITS]) begin
          cross_d = 1'b1;
          state_d = FIX;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      ea_q    <= '0;
      cross_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ea_q    <= ea_d;
      cross_q <= cross_d;
    end
  end

  assign EA_VALID   = (state_q == DONE);
  assign BUSY       = (state_q == FIX);
  assign PAGE_CROSS = cross_q;

`ifdef AGU_PENALTY_CNT_EN
  logic [15:0] pen_q, pen_d;

  always_comb begin
    pen_d = pen_q;
    if ((state_q == FIX) && (pen_q != 16'hFFFF)) begin
      pen_d = pen_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pen_q <= '0;
    end else begin
      pen_q <= pen_d;
    end
  end

  assign PENALTY_CNT = pen_q;
`endif

  addr_src_mux #(
    .ADDR_W     (ADDR_W),
    .PAGE_BITS  (PAGE_BITS),
    .STACK_PAGE (STACK_PAGE)
  ) u_mux (
    .sel_i (SELECT_ADRESS),
    .pc_i  (OUT_PC),
    .mar_i (OUT_MAR),
    .ea_i  (ea_q),
    .sp_i  (SP),
    .vec_i (VECTOR_ADDR),
    .bus_o (OUT_ADRESS_BUS)
  );

endmodule

// File: tb/tb_addr_gen_unit.sv
// Directed self-checking bench for addr_gen_unit.
// Penalty counter checks compile in when AGU_PENALTY_CNT_EN is defined.
module tb_addr_gen_unit;

  logic        CLK;
  logic        RESET_N;
  logic [15:0] OUT_PC;
  logic [15:0] OUT_MAR;
  logic [15:0] VECTOR_ADDR;
  logic [7:0]  SP;
  logic [15:0] BASE_ADDR;
  logic [7:0]  INDEX;
  logic        ZP_MODE;
  logic        START;
  logic [2:0]  SELECT_ADRESS;
  logic [15:0] OUT_ADRESS_BUS;
  logic        EA_VALID;
  logic        PAGE_CROSS;
  logic        BUSY;
`ifdef AGU_PENALTY_CNT_EN
  logic [15:0] PENALTY_CNT;
`endif

  int checks = 0;
  int errors = 0;

  addr_gen_unit #(
    .ADDR_W     (16),
    .PAGE_BITS  (8),
    .STACK_PAGE (1)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .OUT_PC         (OUT_PC),
    .OUT_MAR        (OUT_MAR),
    .VECTOR_ADDR    (VECTOR_ADDR),
    .SP             (SP),
    .BASE_ADDR      (BASE_ADDR),
    .INDEX          (INDEX),
    .ZP_MODE        (ZP_MODE),
    .START          (START),
    .SELECT_ADRESS  (SELECT_ADRESS),
    .OUT_ADRESS_BUS (OUT_ADRESS_BUS),
    .EA_VALID       (EA_VALID),
    .PAGE_CROSS     (PAGE_CROSS),
    .BUSY           (BUSY)
`ifdef AGU_PENALTY_CNT_EN
    ,
    .PENALTY_CNT    (PENALTY_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_bus(input string n, input logic [15:0] exp);
    checks++;
    if (OUT_ADRESS_BUS !== exp) begin
      errors++;
      $display("FAIL %s bus got %h exp %h", n, OUT_ADRESS_BUS, exp);
    end
  endtask

  task automatic chk_flags(input string n, input logic v,
                           input logic pc, input logic b);
    checks++;
    if ({EA_VALID, PAGE_CROSS, BUSY} !== {v, pc, b}) begin
      errors++;
      $display("FAIL %s flags(v,pc,busy) got %b%b%b exp %b%b%b",
               n, EA_VALID, PAGE_CROSS, BUSY, v, pc, b);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    OUT_PC = 16'hC000; OUT_MAR = 16'h5A5A;
    VECTOR_ADDR = 16'hFFFC; SP = 8'hFD;
    BASE_ADDR = 16'h0; INDEX = 8'h0;
    ZP_MODE = 1'b0; START = 1'b0;
    SELECT_ADRESS = 3'b000;
    tick(); tick();
    chk_bus("reset_pc", 16'hC000);
    chk_flags("reset_flags", 1'b0, 1'b0, 1'b0);
    SELECT_ADRESS = 3'b010;
    #1;
    chk_bus("reset_ea", 16'h0000);
    RESET_N = 1'b1;
    tick();
    chk_flags("post_reset_flags", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_no_cross();
    SELECT_ADRESS = 3'b010;
    BASE_ADDR = 16'h1234; INDEX = 8'h10; ZP_MODE = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk_flags("nc_done", 1'b1, 1'b0, 1'b0);
    chk_bus("nc_ea", 16'h1244);
    tick();
    chk_flags("nc_idle", 1'b0, 1'b0, 1'b0);
    chk_bus("nc_hold", 16'h1244);
  endtask

  task automatic test_cross();
    SELECT_ADRESS = 3'b010;
    BASE_ADDR = 16'h12F0; INDEX = 8'h20; ZP_MODE = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk_flags("cr_fix", 1'b0, 1'b1, 1'b1);
    chk_bus("cr_dummy", 16'h1210);
    tick();
    chk_flags("cr_done", 1'b1, 1'b1, 1'b0);
    chk_bus("cr_ea", 16'h1310);
    tick();
    chk_flags("cr_idle_hold", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_zero_page();
    SELECT_ADRESS = 3'b010;
    BASE_ADDR = 16'h00F0; INDEX = 8'h20; ZP_MODE = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0; ZP_MODE = 1'b0;
    chk_flags("zp_done", 1'b1, 1'b0, 1'b0);
    chk_bus("zp_ea", 16'h0010);
  endtask

  task automatic test_wrap_abort();
    SELECT_ADRESS = 3'b010;
    BASE_ADDR = 16'hFFF0; INDEX = 8'h20; ZP_MODE = 1'b0;
    START = 1'b1;
    tick();
    chk_flags("wr_fix", 1'b0, 1'b1, 1'b1);
    chk_bus("wr_dummy", 16'hFF10);
    BASE_ADDR = 16'h1234; INDEX = 8'h01;
    tick();
    START = 1'b0;
    chk_flags("wr_done", 1'b1, 1'b1, 1'b0);
    chk_bus("wr_ea", 16'h0010);
`ifdef AGU_PENALTY_CNT_EN
    checks++;
    if (PENALTY_CNT !== 16'd2) begin
      errors++;
      $display("FAIL penalty got %0d exp 2", PENALTY_CNT);
    end
`endif
    tick();
    chk_flags("wr_idle", 1'b0, 1'b1, 1'b0);
    BASE_ADDR = 16'hFFF0; INDEX = 8'h20;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk_flags("ab_fix", 1'b0, 1'b1, 1'b1);
    RESET_N = 1'b0;
    #1;
    chk_flags("ab_reset", 1'b0, 1'b0, 1'b0);
    chk_bus("ab_ea", 16'h0000);
    tick();
    RESET_N = 1'b1;
    tick();
    chk_flags("ab_no_valid", 1'b0, 1'b0, 1'b0);
    tick();
    chk_flags("ab_no_valid2", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mux();
    SP = 8'hFD; SELECT_ADRESS = 3'b011;
    #1;
    chk_bus("mux_stack", 16'h01FD);
    VECTOR_ADDR = 16'hFFFC; SELECT_ADRESS = 3'b100;
    #1;
    chk_bus("mux_vec", 16'hFFFC);
    OUT_MAR = 16'hBEEF; SELECT_ADRESS = 3'b001;
    #1;
    chk_bus("mux_mar", 16'hBEEF);
    SELECT_ADRESS = 3'b101;
    #1;
    chk_bus("mux_101", 16'h0000);
    SELECT_ADRESS = 3'b111;
    #1;
    chk_bus("mux_111", 16'h0000);
    OUT_PC = 16'h8001; SELECT_ADRESS = 3'b000;
    #1;
    chk_bus("mux_pc", 16'h8001);
  endtask

  initial begin
    test_reset();
    test_no_cross();
    test_cross();
    test_zero_page();
    test_wrap_abort();
    test_mux();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
